fp8_to_int12_decoder: RTL

- Converts the 8-bit floating-point format back to 12-bit two's complement. The format is sign bit, 3-bit exponent, 4-bit mantissa, with value = (-1)^S * M * 2^E.
- It is the decode direction of the linear-to-floating-point converter and sits downstream of the encoder's rounding/saturation stage.
- It is iterative: one left shift of the magnitude per clock for each exponent step, with valid/ready handshakes on input and output.

---
 rtl/fp8_to_int12_decoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/fp8_to_int12_decoder.sv
// Iterative decoder from {sign, exp, mant} floating point to two's-complement integer.
// The magnitude is shifted left once per clock per exponent step, then negated if needed.
module fp8_to_int12_decoder #(
   parameter int EXP_W  = 3,
   parameter int MANT_W = 4,
   parameter int OUT_W  = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [EXP_W+MANT_W:0]     fp_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_W-1:0]          result,
   output logic                      noncanon,
   output logic                      busy
);

   // Handshake: a word moves on an edge where valid && ready are both high.
   // in_ready is high only in IDLE; out_valid only in DONE, where result is held.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [OUT_W-1:0]    mag_q, mag_d;
   logic [EXP_W-1:0]    cnt_q, cnt_d;
   logic                sgn_q, sgn_d;
   logic [OUT_W-1:0]    result_q, result_d;
   logic                noncanon_q, noncanon_d;

   logic                in_sgn;
   logic [EXP_W-1:0]    in_exp;
   logic [MANT_W-1:0]   in_mant;

   assign in_sgn  = fp_in[EXP_W+MANT_W];
   assign in_exp  = fp_in[EXP_W+MANT_W-1:MANT_W];
   assign in_mant = fp_in[MANT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mag_q      <= '0;
         cnt_q      <= '0;
         sgn_q      <= 1'b0;
         result_q   <= '0;
         noncanon_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         cnt_q      <= cnt_d;
         sgn_q      <= sgn_d;
         result_q   <= result_d;
         noncanon_q <= noncanon_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      cnt_d      = cnt_q;
      sgn_d      = sgn_q;
      result_d   = result_q;
      noncanon_d = noncanon_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sgn_d      = in_sgn;
               cnt_d      = in_exp;
               mag_d      = {{(OUT_W-MANT_W){1'b0}}, in_mant};
               noncanon_d = (in_exp != '0) && !in_mant[MANT_W-1];
               state_d    = (in_exp != '0) ? SHIFT : SIGN;
            end
         end
         SHIFT: begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - EXP_W'(1);
            if (cnt_q == EXP_W'(1)) state_d = SIGN;
         end
         SIGN: begin
            // Negative zero folds to 0 because ~0 + 1 wraps at OUT_W bits.
            result_d = sgn_q ? (~mag_q + OUT_W'(1)) : mag_q;
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign noncanon  = noncanon_q;

endmodule
